// File: rtl/alu_resp_monitor_if.sv
// Shared bus between the ALU stimulus side and alu_resp_monitor.
// Stimulus drives beat/clear as master; the monitor returns ready, statistics and error capture.
interface alu_resp_monitor_if #(
  parameter int CNT_W = 16
);
  // Handshake: a beat transfers on a rising edge where in_valid && in_ready are both 1; in_valid
  // may rise freely, and a beat offered while in_ready=0 is simply not taken.
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       a;
  logic [7:0]       b;
  logic [3:0]       sel;
  logic [7:0]       alu_out;
  logic             carry_out;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic             err_flag;
  logic [3:0]       err_sel;
  logic [7:0]       err_a;
  logic [7:0]       err_b;
  logic [8:0]       err_exp;
  logic [8:0]       err_got;
  logic             busy;
  logic [1:0]       dbg_state;

  modport master (
    output clear, in_valid, a, b, sel, alu_out, carry_out,
    input  in_ready, pass_cnt, fail_cnt, err_flag, err_sel, err_a, err_b,
           err_exp, err_got, busy, dbg_state
  );

  modport slave (
    input  clear, in_valid, a, b, sel, alu_out, carry_out,
    output in_ready, pass_cnt, fail_cnt, err_flag, err_sel, err_a, err_b,
           err_exp, err_got, busy, dbg_state
  );
endinterface

// File: rtl/alu_resp_monitor.sv
// Response monitor for the 8-bit ALU: recomputes each beat, counts pass/fail, captures first error.
// Optional macro ALU_MON_STOP_ON_ERR_EN: halt intake (in_ready=0) after the first mismatch until clear.
module alu_resp_monitor #(
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst_n,
  alu_resp_monitor_if.slave bus
);

`ifdef ALU_MON_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_vld;
  logic [7:0]       r_a;
  logic [7:0]       r_b;
  logic [3:0]       r_sel;
  logic [8:0]       r_got;

  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic             r_err_flag;
  logic [3:0]       r_err_sel;
  logic [7:0]       r_err_a;
  logic [7:0]       r_err_b;
  logic [8:0]       r_err_exp;
  logic [8:0]       r_err_got;

  logic             w_ready;
  logic             w_accept;
  logic [8:0]       w_sum;
  logic [15:0]      w_prod;
  logic [7:0]       w_res;
  logic [8:0]       w_exp;
  logic             w_mismatch;

  assign w_ready  = (r_state != ST_HALT);
  assign w_accept = bus.in_valid && w_ready;

  // Reference model on the captured operands; carry is always the adder carry.
  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_prod = {8'd0, r_a} * {8'd0, r_b};

  always_comb begin
    w_res = 8'h00;
    case (r_sel)
      4'd0:  w_res = w_sum[7:0];
      4'd1:  w_res = r_a - r_b;
      4'd2:  w_res = w_prod[7:0];
      4'd3:  w_res = (r_b == 8'h00) ? 8'h00 : (r_a / r_b);
      4'd4:  w_res = {r_a[6:0], 1'b0};
      4'd5:  w_res = {1'b0, r_a[7:1]};
      4'd6:  w_res = {r_a[6:0], r_a[7]};
      4'd7:  w_res = {r_a[0], r_a[7:1]};
      4'd8:  w_res = r_a & r_b;
      4'd9:  w_res = r_a | r_b;
      4'd10: w_res = r_a ^ r_b;
      4'd11: w_res = ~(r_a | r_b);
      4'd12: w_res = ~(r_a & r_b);
      4'd13: w_res = ~(r_a ^ r_b);
      4'd14: w_res = {7'd0, (r_a > r_b)};
      4'd15: w_res = {7'd0, (r_a == r_b)};
      default: w_res = 8'h00;
    endcase
  end

  assign w_exp      = {w_sum[8], w_res};
  assign w_mismatch = r_vld && (w_exp != r_got);

  always_comb begin
    w_state_nxt = r_state;
    if (bus.clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_accept) w_state_nxt = ST_CHECK;
        ST_CHECK: begin
          if (STOP_ON_ERR && w_mismatch) w_state_nxt = ST_HALT;
          else if (w_accept)             w_state_nxt = ST_CHECK;
          else                           w_state_nxt = ST_IDLE;
        end
        ST_HALT:  w_state_nxt = ST_HALT;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Compare stage and statistics; clear wins over a compare completing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld      <= 1'b0;
      r_a        <= 8'h00;
      r_b        <= 8'h00;
      r_sel      <= 4'h0;
      r_got      <= 9'h000;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_err_flag <= 1'b0;
      r_err_sel  <= 4'h0;
      r_err_a    <= 8'h00;
      r_err_b    <= 8'h00;
      r_err_exp  <= 9'h000;
      r_err_got  <= 9'h000;
    end else if (bus.clear) begin
      r_vld      <= 1'b0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_err_flag <= 1'b0;
      r_err_sel  <= 4'h0;
      r_err_a    <= 8'h00;
      r_err_b    <= 8'h00;
      r_err_exp  <= 9'h000;
      r_err_got  <= 9'h000;
    end else begin
      r_vld <= w_accept;
      if (w_accept) begin
        r_a   <= bus.a;
        r_b   <= bus.b;
        r_sel <= bus.sel;
        r_got <= {bus.carry_out, bus.alu_out};
      end
      if (r_vld) begin
        if (!w_mismatch) begin
          if (r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + 1'b1;
        end else begin
          if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + 1'b1;
          if (!r_err_flag) begin
            r_err_flag <= 1'b1;
            r_err_sel  <= r_sel;
            r_err_a    <= r_a;
            r_err_b    <= r_b;
            r_err_exp  <= w_exp;
            r_err_got  <= r_got;
          end
        end
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.busy      = r_vld;
  assign bus.pass_cnt  = r_pass_cnt;
  assign bus.fail_cnt  = r_fail_cnt;
  assign bus.err_flag  = r_err_flag;
  assign bus.err_sel   = r_err_sel;
  assign bus.err_a     = r_err_a;
  assign bus.err_b     = r_err_b;
  assign bus.err_exp   = r_err_exp;
  assign bus.err_got   = r_err_got;
  assign bus.dbg_state = r_state;

endmodule

// File: doc/alu_resp_monitor.md
# alu_resp_monitor

Synthesizable response monitor at the receiving end of the ALU stimulus interface. The stimulus side drives operand/opcode beats into the combinational `alu`. This block samples each beat together with the ALU response, recomputes the expected result with its own reference model, and keeps pass/fail statistics. On a mismatch it captures the first failing beat. It sits alongside the DUT on the shared interface and serves as a self-checking sink for bring-up and regression.

## Interface
Parameters:
- `CNT_W`, 16, width of the pass and fail counters.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous clear of counters, error capture and FSM.
- `in_valid`  in  1  beat present on `a`/`b`/`sel`/`alu_out`/`carry_out`.
- `in_ready`  out  1  monitor accepts a beat this cycle.
- `a`, `b`  in  8  operands as driven to the ALU.
- `sel`  in  4  ALU opcode.
- `alu_out`  in  8  ALU result under check.
- `carry_out`  in  1  ALU carry under check.
- `pass_cnt`  out  CNT_W  beats that matched.
- `fail_cnt`  out  CNT_W  beats that mismatched.
- `err_flag`  out  1  sticky; at least one mismatch seen.
- `err_sel`  out  4  opcode of first mismatch.
- `err_a`, `err_b`  out  8  operands of first mismatch.
- `err_exp`  out  9  expected {carry, result} of first mismatch.
- `err_got`  out  9  observed {carry, result} of first mismatch.
- `busy`  out  1  a captured beat is in the compare stage.

## Operation
- The reference model is computed on captured operands, 8-bit result truncated:
  - `sel` 0 add, 1 sub, 2 mul (low 8 bits), 3 div (`b`=0 gives 8'h00).
  - 4 `a<<1`, 5 `a>>1`, 6 rotate-left by 1, 7 rotate-right by 1.
  - 8 and, 9 or, 10 xor, 11 nor, 12 nand, 13 xnor.
  - 14 `(a>b)?1:0`, 15 `(a==b)?1:0`.
- Expected carry for every opcode is bit 8 of the 9-bit sum `{0,a}+{0,b}`.
- A beat is a pass only if both the result and the carry match.
- FSM states:
  - IDLE: no beat in flight. Moves to CHECK on an accepted beat.
  - CHECK: compare stage occupied. Stays in CHECK on a back-to-back accept, otherwise returns to IDLE.
  - HALT: only with the macro defined, entered on a mismatch. Left only by `clear` or reset.
- `in_ready` = 1 in IDLE and CHECK, and 0 in HALT.
- On a mismatch, `fail_cnt` increments. If `err_flag` was 0, the `err_*` fields are loaded and `err_flag` is set. Later mismatches never overwrite the `err_*` fields.
- On a match, `pass_cnt` increments.
- Counters saturate at all-ones and do not wrap.
- `clear` has priority over a compare completing in the same cycle: counters go to 0, `err_*` go to 0, and the FSM goes to IDLE. A beat accepted in the same cycle as `clear` is discarded.

## Timing
- Reset values: `in_ready`=1, `busy`=0, `err_flag`=0, FSM IDLE, and every counter and `err_*` field at 0.
- A beat is accepted at edge N when `in_valid && in_ready`. It is registered into the compare stage, and `busy`=1 after edge N.
- Counters and error capture update at edge N+1, so latency is 2 edges from accept to visible statistics.
- One beat per cycle is sustained with no bubbles.
- An asynchronous reset mid-operation drops the in-flight beat, and no counter is updated for it.
- `in_valid` while `in_ready`=0 is ignored and not counted.

## Configuration
- `ALU_MON_STOP_ON_ERR_EN` defined:
  - The first mismatch moves the FSM to HALT, and `in_ready` drops after edge N+1.
  - Beats presented in HALT are not counted.
  - A beat accepted at edge N+1 (while the failing beat is compared) is still checked and counted.
- Not defined: HALT does not exist, `in_ready` stays 1 after reset, and all beats are counted indefinitely.

## Test plan
- Reset, then `a`=8'hF0, `b`=8'h20, `sel`=0, `alu_out`=8'h10, `carry_out`=1 → `pass_cnt`=1 two edges after accept, `err_flag`=0.
- `sel`=5, `a`=8'h81, `alu_out`=8'h40, `carry_out`=0 with `b`=8'h00 → pass. Then `alu_out`=8'hC0 → `fail_cnt`=1, `err_exp`=9'h040, `err_got`=9'h0C0, `err_sel`=5.
- `sel`=3 with `b`=0, `alu_out`=8'h00 → pass; a second mismatch after an earlier failure leaves `err_*` unchanged while `fail_cnt`=2.
- Preload `pass_cnt` to all-ones via CNT_W=4 and 16 matching beats → `pass_cnt` holds 4'hF.
- With `ALU_MON_STOP_ON_ERR_EN`: a mismatch → `in_ready`=0 and further beats are ignored. `clear` → all zero, `in_ready`=1.
- `clear` asserted in the same cycle as a compare completes → counters read 0 on the next cycle and the compared beat is not counted.
